mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Parametrised multicycle MIPS control unit: the next generation of the lab controller, adding memory wait-state handshaking with a timeout, bne/andi/ori/slti, optional jal, and a sticky trap on illegal opcodes or memory timeout. It sits between the instruction register (op/funct) and the multicycle datapath. It drives every datapath mux select and write strobe and owns the only FSM in the core.

## Interface
Parameters
- ALUCTRL_W, 4: width of alucontrol.
- MAX_WAIT, 15: maximum consecutive wait cycles in a memory state; 0 disables the timeout.
- WAIT_W, 4: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  6  instr[31:26].
- funct  in  6  instr[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pcen, irwrite, regwrite, memwrite  out  1  write strobes.
- alusrca, iord, extop  out  1  extop=1 zero-extends imm (andi/ori).
- regdst, wdsel, alusrcb, pcsrc  out  2  regdst 00 rt/01 rd/10 r31; wdsel 00 ALUOut/01 Data/10 PC.
- alucontrol  out  ALUCTRL_W  add 0000, sub 0010, and 0100, or 0101, slt 1010.
- halted, illegal, memerr  out  1  sticky status.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IEX, IWB, JEX, JALEX, TRAP.
- Unlisted outputs are 0.
- FETCH: iord=0, alusrcb=01, add, pcsrc=00. irwrite=pcen=mem_ready. Advance on mem_ready.
- DECODE: alusrcb=11, add. Branches on op:
  - lw/sw → MEMADR; R-type → RTYPEEX.
  - beq → BEQEX; bne → BNEEX.
  - addi/andi/ori/slti → IEX; j → JEX; jal → JALEX.
  - Any other op → TRAP with illegal=1.
- MEMADR: alusrca=1, alusrcb=10, add. lw → MEMRD, sw → MEMWR.
- MEMRD: iord=1; hold until mem_ready, then → MEMWB.
- MEMWB: regdst=00, wdsel=01, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1 held while waiting; advance to FETCH on mem_ready.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct (add/sub/and/or/slt).
  - Unknown funct → TRAP with illegal=1, no register write.
- RTYPEWB: regdst=01, wdsel=00, regwrite=1 → FETCH.
- BEQEX / BNEEX: alusrca=1, sub, pcsrc=01. pcen=zero (BEQEX) or !zero (BNEEX) → FETCH.
- IEX: alusrca=1, alusrcb=10, alucontrol add/and/or/slt for addi/andi/ori/slti; extop=1 for andi/ori.
- IWB: regdst=00, wdsel=00, regwrite=1 → FETCH.
- JEX: pcsrc=10, pcen=1 → FETCH.
- JALEX: pcsrc=10, pcen=1, regwrite=1, regdst=10, wdsel=10 (PC already holds PC+4) → FETCH.
- TRAP: all strobes 0, halted=1; only reset exits.
- Wait counter: clears on every state entry and increments each FETCH/MEMRD/MEMWR cycle with mem_ready=0.
  - If counter == MAX_WAIT and mem_ready=0 (MAX_WAIT≠0) → TRAP with memerr=1.
  - mem_ready in that same cycle wins: normal advance.

## Timing
- Reset (async): state=FETCH, counter=0, halted/illegal/memerr=0.
- While reset is high, all strobes are forced to 0.
- Strobes and selects are Moore-decoded from state. Exceptions: pcen/irwrite in FETCH and pcen in branch states, which are combinational on mem_ready/zero.
- Zero-wait latencies:
  - lw 5 cycles.
  - sw, R-type, I-type 4 cycles.
  - beq, bne, j, jal 3 cycles.
- Each wait cycle adds 1.
- Timeout: TRAP is entered on the edge after the (MAX_WAIT+1)th consecutive not-ready cycle.
- Reset asserted mid-instruction aborts immediately; no partial write strobe survives.

## Configuration
- MC_CTRL_JAL_EN defined: JALEX exists; op 000011 executes jal.
- MC_CTRL_JAL_EN undefined: JALEX is omitted; op 000011 decodes as illegal → TRAP. regdst=10 and wdsel=10 are never driven.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum;
  - opcode constants (LW, SW, RTYPE, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J, JAL);
  - funct constants;
  - alucontrol encodings;
  - regdst/wdsel/alusrcb/pcsrc select constants.
- One sub-module, mc_aludec: combinational mapping of a 2-bit aluop plus funct/op to alucontrol, with an invalid flag feeding the illegal trap.

## Test plan
- Zero-wait lw, add, beq (taken) with mem_ready tied 1 → state trace F,D,MA,MR,MWB / F,D,RX,RWB / F,D,BEQ, with pcen=1 in BEQEX when zero=1.
- bne with zero=1 → pcen=0 in BNEEX. With zero=0 → pcen=1, pcsrc=01.
- andi → extop=1, alucontrol=0100. slti → extop=0, alucontrol=1010. Both write with regdst=00.
- mem_ready low 3 cycles during MEMWR → memwrite held 4 cycles, a single FETCH entry, no timeout.
- mem_ready low 16 cycles in FETCH (MAX_WAIT=15) → TRAP, memerr=1, halted=1, strobes 0 until reset.
- op=000011:
  - with MC_CTRL_JAL_EN → JALEX with regdst=10, wdsel=10, regwrite=1.
  - without → illegal=1, TRAP.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
// MC_CTRL_JAL_EN adds the JALEX state and jal decoding.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, BNEEX, IEX, IWB, JEX,
`ifdef MC_CTRL_JAL_EN
    JALEX,
`endif
    TRAP
  } state_t;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] JAL   = 6'b000011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] SLTI  = 6'b001010;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLT = 4'b1010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_DATA   = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] SB_REG   = 2'b00;
  localparam logic [1:0] SB_FOUR  = 2'b01;
  localparam logic [1:0] SB_IMM   = 2'b10;
  localparam logic [1:0] SB_BROFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_aludec.sv
// ALU decoder: maps aluop plus funct/op to an alucontrol code and flags
// encodings the datapath cannot execute.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       invalid
);

  always_comb begin
    alucontrol = ALU_ADD;
    invalid    = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT:
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: invalid    = 1'b1;
        endcase
      default:
        case (op)
          ADDI:    alucontrol = ALU_ADD;
          ANDI:    alucontrol = ALU_AND;
          ORI:     alucontrol = ALU_OR;
          SLTI:    alucontrol = ALU_SLT;
          default: invalid    = 1'b1;
        endcase
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with memory wait-state timeout and sticky trap.
// Define MC_CTRL_JAL_EN to build jal support (JALEX state).
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter int MAX_WAIT  = 15,
  parameter int WAIT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pcen,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 memwrite,
  output logic                 alusrca,
  output logic                 iord,
  output logic                 extop,
  output logic [1:0]           regdst,
  output logic [1:0]           wdsel,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 halted,
  output logic                 illegal,
  output logic                 memerr
);

  state_t              state, wait_next;
  logic   [WAIT_W-1:0] wcnt;
  logic   [1:0]        aluop;
  logic   [3:0]        alu_ctl;
  logic                alu_invalid;
  logic                timeout;

  mc_aludec u_aludec (
    .aluop      (aluop),
    .op         (op),
    .funct      (funct),
    .alucontrol (alu_ctl),
    .invalid    (alu_invalid)
  );

  assign alucontrol = ALUCTRL_W'(alu_ctl);

  always_comb begin
    timeout = (MAX_WAIT != 0) && !mem_ready && (wcnt == WAIT_W'(MAX_WAIT));
    case (state)
      FETCH:   wait_next = DECODE;
      MEMRD:   wait_next = MEMWB;
      default: wait_next = FETCH;
    endcase
  end

  // Counter defaults to clear; it only survives a stalled memory cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      wcnt    <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      memerr  <= 1'b0;
    end else begin
      wcnt <= '0;
      case (state)
        FETCH, MEMRD, MEMWR:
          if (mem_ready) state <= wait_next;
          else if (timeout) begin
            state  <= TRAP;
            memerr <= 1'b1;
            halted <= 1'b1;
          end else wcnt <= wcnt + 1'b1;
        DECODE:
          case (op)
            LW, SW:                state <= MEMADR;
            RTYPE:                 state <= RTYPEEX;
            BEQ:                   state <= BEQEX;
            BNE:                   state <= BNEEX;
            ADDI, ANDI, ORI, SLTI: state <= IEX;
            J:                     state <= JEX;
`ifdef MC_CTRL_JAL_EN
            JAL:                   state <= JALEX;
`endif
            default: begin
              state   <= TRAP;
              illegal <= 1'b1;
              halted  <= 1'b1;
            end
          endcase
        MEMADR: state <= (op == SW) ? MEMWR : MEMRD;
        RTYPEEX:
          if (alu_invalid) begin
            state   <= TRAP;
            illegal <= 1'b1;
            halted  <= 1'b1;
          end else state <= RTYPEWB;
        IEX:  state <= IWB;
        TRAP: state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    pcen     = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    extop    = 1'b0;
    regdst   = RD_RT;
    wdsel    = WD_ALUOUT;
    alusrcb  = SB_REG;
    pcsrc    = PC_ALU;
    aluop    = ALUOP_ADD;
    if (!reset) begin
      case (state)
        FETCH: begin
          alusrcb = SB_FOUR;
          irwrite = mem_ready;
          pcen    = mem_ready;
        end
        DECODE:  alusrcb = SB_BROFF;
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SB_IMM;
        end
        MEMRD:   iord = 1'b1;
        MEMWB: begin
          wdsel    = WD_DATA;
          regwrite = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        RTYPEWB: begin
          regdst   = RD_RD;
          regwrite = 1'b1;
        end
        BEQEX, BNEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PC_ALUOUT;
          pcen    = (state == BEQEX) ? zero : !zero;
        end
        IEX: begin
          alusrca = 1'b1;
          alusrcb = SB_IMM;
          aluop   = ALUOP_IMM;
          extop   = (op == ANDI) || (op == ORI);
        end
        IWB:     regwrite = 1'b1;
        JEX: begin
          pcsrc = PC_JUMP;
          pcen  = 1'b1;
        end
`ifdef MC_CTRL_JAL_EN
        JALEX: begin
          pcsrc    = PC_JUMP;
          pcen     = 1'b1;
          regwrite = 1'b1;
          regdst   = RD_R31;
          wdsel    = WD_PC;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl (default parameters).
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk, reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcen, irwrite, regwrite, memwrite, alusrca, iord, extop;
  logic [1:0] regdst, wdsel, alusrcb, pcsrc;
  logic [3:0] alucontrol;
  logic       halted, illegal, memerr;
  int         n_cmp, n_err, wr_cycles;

  mc_ctrl #(.ALUCTRL_W(4), .MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .irwrite(irwrite),
    .regwrite(regwrite), .memwrite(memwrite), .alusrca(alusrca),
    .iord(iord), .extop(extop), .regdst(regdst), .wdsel(wdsel),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .halted(halted), .illegal(illegal), .memerr(memerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic st(input string tag, input state_t s);
    chk(tag, 32'(dut.state), 32'(s));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = LW; funct = F_ADD;
    cyc();
    #1;
    chk("rst_pcen", pcen, 0);
    chk("rst_irwrite", irwrite, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_memerr", memerr, 0);
    st("rst_state", FETCH);
    reset = 1'b0;
    #1;
    chk("f_pcen", pcen, 1);
    chk("f_irwrite", irwrite, 1);
    chk("f_alusrcb", alusrcb, 2'b01);

    // lw, zero wait
    cyc(); st("lw_dec", DECODE); chk("dec_alusrcb", alusrcb, 2'b11); chk("dec_pcen", pcen, 0);
    cyc(); st("lw_ma", MEMADR); chk("ma_alusrca", alusrca, 1); chk("ma_alusrcb", alusrcb, 2'b10);
    cyc(); st("lw_mr", MEMRD); chk("mr_iord", iord, 1);
    cyc(); st("lw_mwb", MEMWB); chk("mwb_regwrite", regwrite, 1); chk("mwb_wdsel", wdsel, 2'b01);
    chk("mwb_regdst", regdst, 2'b00);
    cyc(); st("lw_done", FETCH);

    // add / sub
    op = RTYPE; funct = F_ADD;
    cyc(); st("add_dec", DECODE);
    cyc(); st("add_rx", RTYPEEX); chk("add_alu", alucontrol, 4'b0000); chk("rx_alusrca", alusrca, 1);
    chk("rx_alusrcb", alusrcb, 2'b00);
    cyc(); st("add_rwb", RTYPEWB); chk("rwb_regdst", regdst, 2'b01); chk("rwb_regwrite", regwrite, 1);
    cyc(); st("add_done", FETCH);
    funct = F_SUB;
    cyc(); cyc(); chk("sub_alu", alucontrol, 4'b0010);
    funct = F_OR; #1; chk("or_alu", alucontrol, 4'b0101);
    cyc(); cyc(); st("sub_done", FETCH);

    // beq taken
    op = BEQ; zero = 1'b1;
    cyc(); cyc(); st("beq_ex", BEQEX);
    chk("beq_pcen", pcen, 1); chk("beq_pcsrc", pcsrc, 2'b01); chk("beq_alu", alucontrol, 4'b0010);
    zero = 1'b0; #1; chk("beq_nt_pcen", pcen, 0);
    cyc(); st("beq_done", FETCH);

    // bne
    op = BNE; zero = 1'b1;
    cyc(); cyc(); st("bne_ex", BNEEX); chk("bne_z1_pcen", pcen, 0);
    zero = 1'b0; #1; chk("bne_z0_pcen", pcen, 1); chk("bne_pcsrc", pcsrc, 2'b01);
    cyc(); st("bne_done", FETCH);

    // andi / slti
    op = ANDI;
    cyc(); cyc(); st("andi_iex", IEX); chk("andi_extop", extop, 1); chk("andi_alu", alucontrol, 4'b0100);
    chk("iex_alusrcb", alusrcb, 2'b10);
    cyc(); st("andi_iwb", IWB); chk("andi_regwrite", regwrite, 1); chk("andi_regdst", regdst, 2'b00);
    chk("iwb_extop", extop, 0);
    cyc(); st("andi_done", FETCH);
    op = SLTI;
    cyc(); cyc(); chk("slti_extop", extop, 0); chk("slti_alu", alucontrol, 4'b1010);
    cyc(); chk("slti_regwrite", regwrite, 1); chk("slti_regdst", regdst, 2'b00);
    cyc(); st("slti_done", FETCH);

    // j
    op = J;
    cyc(); cyc(); st("j_ex", JEX); chk("j_pcen", pcen, 1); chk("j_pcsrc", pcsrc, 2'b10);
    cyc(); st("j_done", FETCH);

    // sw with three wait cycles
    op = SW;
    cyc(); cyc(); cyc(); st("sw_mw", MEMWR);
    wr_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (memwrite) wr_cycles++;
      st("sw_hold", MEMWR);
      cyc();
    end
    st("sw_done", FETCH);
    chk("sw_wr_cycles", wr_cycles, 4);
    chk("sw_memerr", memerr, 0);

    // fetch timeout: 16 not-ready cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      st("tmo_wait", FETCH);
      chk("tmo_pcen", pcen, 0);
      cyc();
    end
    st("tmo_trap", TRAP);
    chk("tmo_memerr", memerr, 1); chk("tmo_halted", halted, 1); chk("tmo_illegal", illegal, 0);
    mem_ready = 1'b1; #1;
    chk("trap_pcen", pcen, 0); chk("trap_irwrite", irwrite, 0);
    cyc(); cyc(); st("trap_stays", TRAP); chk("trap_halted", halted, 1);
    do_reset();
    st("rst2_state", FETCH); chk("rst2_memerr", memerr, 0); chk("rst2_halted", halted, 0);

    // op 000011
    op = JAL;
    cyc(); cyc();
`ifdef MC_CTRL_JAL_EN
    st("jal_ex", JALEX);
    chk("jal_regdst", regdst, 2'b10); chk("jal_wdsel", wdsel, 2'b10);
    chk("jal_regwrite", regwrite, 1); chk("jal_pcen", pcen, 1);
    cyc(); st("jal_done", FETCH);
`else
    st("jal_trap", TRAP); chk("jal_illegal", illegal, 1); chk("jal_halted", halted, 1);
    chk("jal_memerr", memerr, 0);
`endif
    do_reset();

    // unknown funct traps without a register write
    op = RTYPE; funct = 6'b000000;
    cyc(); cyc(); st("badf_rx", RTYPEEX); chk("badf_regwrite", regwrite, 0);
    cyc(); st("badf_trap", TRAP); chk("badf_illegal", illegal, 1);
    do_reset();

    // reset mid-instruction kills the write strobe at once
    op = LW;
    cyc(); cyc(); cyc(); cyc(); chk("abort_pre", regwrite, 1);
    reset = 1'b1; #1;
    chk("abort_regwrite", regwrite, 0); st("abort_state", FETCH);
    cyc(); reset = 1'b0; #1;
    chk("abort_fetch_pcen", pcen, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
